court_bounce: RTL and testbench

//   Parametrised boundary/net collision resolver for the ball. Sits between the ball

---
 rtl/court_pkg.sv | 36 +++
 rtl/bounce_reflect.sv | 47 ++++
 rtl/court_bounce.sv | 155 +++++++++++++++
 tb/tb_court_bounce.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/court_pkg.sv
// rtl/court_pkg.sv - shared constants and encodings for the court bounce resolver
// Purpose: default court geometry, net_case encodings, hit_mask bit indices and
//          reflect direction codes shared by court_bounce and bounce_reflect.
// Ports:   none (package).
package court_pkg;

  localparam int POS_W_D      = 11;
  localparam int VEL_W_D      = 10;
  localparam int X_MIN_D      = 38;
  localparam int X_MAX_D      = 592;
  localparam int Y_MIN_D      = 38;
  localparam int NET_L_D      = 285;
  localparam int NET_R_D      = 335;
  localparam int NET_EDGE_D   = 10;
  localparam int NET_TOP_D    = 270;
  localparam int MIN_SPEED_D  = 10;
  localparam int KICK_SPEED_D = 20;
  localparam int COOLDOWN_D   = 4;

  typedef enum logic [1:0] {
    NC_NONE  = 2'd0,
    NC_LEFT  = 2'd1,
    NC_RIGHT = 2'd2,
    NC_TOP   = 2'd3
  } net_case_e;

  localparam int HIT_LEFT  = 0;
  localparam int HIT_RIGHT = 1;
  localparam int HIT_CEIL  = 2;
  localparam int HIT_NET   = 3;

  // Reflect direction: DIR_POS forces motion toward +axis, DIR_NEG toward -axis.
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/bounce_reflect.sv
// rtl/bounce_reflect.sv - combinational single-axis velocity reflection
// Purpose: reflects a signed velocity toward the direction selected by dir.
//          Slow velocities (|v| <= MIN_SPEED) are replaced by a KICK_SPEED kick;
//          negating the most-negative value saturates to the maximum positive.
// Ports:   v     in  VEL_W  signed velocity
//          dir   in  1      DIR_POS (rpos) or DIR_NEG (rneg)
//          v_out out VEL_W  reflected velocity
module bounce_reflect
  import court_pkg::*;
#(
  parameter int VEL_W      = VEL_W_D,
  parameter int MIN_SPEED  = MIN_SPEED_D,
  parameter int KICK_SPEED = KICK_SPEED_D
) (
  input  logic [VEL_W-1:0] v,
  input  logic             dir,
  output logic [VEL_W-1:0] v_out
);

  localparam logic signed [VEL_W-1:0] MIN_P    = VEL_W'(MIN_SPEED);
  localparam logic signed [VEL_W-1:0] MIN_N    = VEL_W'(-MIN_SPEED);
  localparam logic signed [VEL_W-1:0] KICK_P   = VEL_W'(KICK_SPEED);
  localparam logic signed [VEL_W-1:0] KICK_N   = VEL_W'(-KICK_SPEED);
  localparam logic signed [VEL_W-1:0] V_MOST_N = {1'b1, {(VEL_W-1){1'b0}}};
  localparam logic signed [VEL_W-1:0] V_MAX_P  = {1'b0, {(VEL_W-1){1'b1}}};

  logic signed [VEL_W-1:0] vs;
  logic signed [VEL_W-1:0] neg_v;
  logic                    slow;

  assign vs    = $signed(v);
  // Two's complement negation of the most-negative value wraps; clamp instead.
  assign neg_v = (vs == V_MOST_N) ? V_MAX_P : -vs;
  assign slow  = (vs >= MIN_N) && (vs <= MIN_P);

  always_comb begin
    v_out = v;
    if (dir == DIR_POS) begin
      if (slow)            v_out = KICK_P;
      else if (vs < MIN_N) v_out = neg_v;
    end else begin
      if (slow)            v_out = KICK_N;
      else if (vs > MIN_P) v_out = neg_v;
    end
  end

endmodule

// File: rtl/court_bounce.sv
// rtl/court_bounce.sv - wall, ceiling and net collision resolver for the ball
// Purpose: decodes contact zones from the ball position, reflects the velocity
//          with a minimum-speed kick, applies per-axis re-bounce cooldown and
//          registers the result behind a valid/ready handshake (latency 1).
// Ports:   clk, rst                      clock, synchronous active-high reset
//          in_valid/in_ready             input handshake
//          ball_pos_x/y, ball_v_x/y      signed ball state
//          out_valid/out_ready           output handshake
//          new_ball_v_x/y                resolved velocity
//          hit_mask                      {net,ceiling,right,left} applied contacts
//          net_case                      0 none, 1 left face, 2 right face, 3 top
module court_bounce
  import court_pkg::*;
#(
  parameter int POS_W      = POS_W_D,
  parameter int VEL_W      = VEL_W_D,
  parameter int X_MIN      = X_MIN_D,
  parameter int X_MAX      = X_MAX_D,
  parameter int Y_MIN      = Y_MIN_D,
  parameter int NET_L      = NET_L_D,
  parameter int NET_R      = NET_R_D,
  parameter int NET_EDGE   = NET_EDGE_D,
  parameter int NET_TOP    = NET_TOP_D,
  parameter int MIN_SPEED  = MIN_SPEED_D,
  parameter int KICK_SPEED = KICK_SPEED_D,
  parameter int COOLDOWN   = COOLDOWN_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] ball_pos_x,
  input  logic [POS_W-1:0] ball_pos_y,
  input  logic [VEL_W-1:0] ball_v_x,
  input  logic [VEL_W-1:0] ball_v_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEL_W-1:0] new_ball_v_x,
  output logic [VEL_W-1:0] new_ball_v_y,
  output logic [3:0]       hit_mask,
  output logic [1:0]       net_case
);

  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CW-1:0] COOL_LD = CW'(COOLDOWN);

  localparam logic signed [POS_W-1:0] X_MIN_S   = POS_W'(X_MIN);
  localparam logic signed [POS_W-1:0] X_MAX_S   = POS_W'(X_MAX);
  localparam logic signed [POS_W-1:0] Y_MIN_S   = POS_W'(Y_MIN);
  localparam logic signed [POS_W-1:0] NET_L_S   = POS_W'(NET_L);
  localparam logic signed [POS_W-1:0] NET_R_S   = POS_W'(NET_R);
  localparam logic signed [POS_W-1:0] NET_LI_S  = POS_W'(NET_L + NET_EDGE);
  localparam logic signed [POS_W-1:0] NET_RI_S  = POS_W'(NET_R - NET_EDGE);
  localparam logic signed [POS_W-1:0] NET_TOP_S = POS_W'(NET_TOP);

  logic signed [POS_W-1:0] px, py;
  logic hit_left, hit_right, wall_x, net_zone_y, face_l, face_r;
  logic hit_ceil, net_top, x_contact, y_contact;
  logic x_live, y_live, x_apply, y_apply, accept;
  logic dir_x, dir_y;
  logic [VEL_W-1:0] rx, ry, nvx, nvy;
  logic [3:0]       hm_d;
  net_case_e        nc_d;
  logic [CW-1:0]    cool_x, cool_y, cool_x_d, cool_y_d;

  assign px = $signed(ball_pos_x);
  assign py = $signed(ball_pos_y);

  // Zone decode, first match wins on x: walls shadow the net faces.
  assign hit_left   = (px <= X_MIN_S);
  assign hit_right  = !hit_left && (px >= X_MAX_S);
  assign wall_x     = hit_left || hit_right;
  assign net_zone_y = (py >= NET_TOP_S);
  assign face_l     = !wall_x && net_zone_y && (px >= NET_L_S) && (px <= NET_LI_S);
  assign face_r     = !wall_x && net_zone_y && !face_l && (px >= NET_RI_S) && (px <= NET_R_S);
  assign hit_ceil   = (py <= Y_MIN_S);
  assign net_top    = !hit_ceil && !wall_x && !face_l && !face_r && net_zone_y &&
                      (px > NET_LI_S) && (px < NET_RI_S);
  assign x_contact  = wall_x || face_l || face_r;
  assign y_contact  = hit_ceil || net_top;

  // A non-zero cooldown masks contact on that axis entirely.
  assign x_live  = (cool_x == '0);
  assign y_live  = (cool_y == '0);
  assign x_apply = x_contact && x_live;
  assign y_apply = y_contact && y_live;

  assign dir_x = (hit_left || face_r) ? DIR_POS : DIR_NEG;
  assign dir_y = hit_ceil ? DIR_POS : DIR_NEG;

  bounce_reflect #(.VEL_W(VEL_W), .MIN_SPEED(MIN_SPEED), .KICK_SPEED(KICK_SPEED)) u_reflect_x (
    .v     (ball_v_x),
    .dir   (dir_x),
    .v_out (rx)
  );

  bounce_reflect #(.VEL_W(VEL_W), .MIN_SPEED(MIN_SPEED), .KICK_SPEED(KICK_SPEED)) u_reflect_y (
    .v     (ball_v_y),
    .dir   (dir_y),
    .v_out (ry)
  );

  assign nvx = x_apply ? rx : ball_v_x;
  assign nvy = y_apply ? ry : ball_v_y;

  always_comb begin
    hm_d           = '0;
    hm_d[HIT_LEFT]  = hit_left && x_live;
    hm_d[HIT_RIGHT] = hit_right && x_live;
    hm_d[HIT_CEIL]  = hit_ceil && y_live;
    hm_d[HIT_NET]   = ((face_l || face_r) && x_live) || (net_top && y_live);
  end

  always_comb begin
    nc_d = NC_NONE;
    if (face_l && x_live)       nc_d = NC_LEFT;
    else if (face_r && x_live)  nc_d = NC_RIGHT;
    else if (net_top && y_live) nc_d = NC_TOP;
  end

  always_comb begin
    cool_x_d = '0;
    cool_y_d = '0;
    if (!x_live)      cool_x_d = cool_x - CW'(1);
    else if (x_apply) cool_x_d = COOL_LD;
    if (!y_live)      cool_y_d = cool_y - CW'(1);
    else if (y_apply) cool_y_d = COOL_LD;
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      new_ball_v_x <= '0;
      new_ball_v_y <= '0;
      hit_mask     <= '0;
      net_case     <= '0;
      cool_x       <= '0;
      cool_y       <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      new_ball_v_x <= nvx;
      new_ball_v_y <= nvy;
      hit_mask     <= hm_d;
      net_case     <= nc_d;
      cool_x       <= cool_x_d;
      cool_y       <= cool_y_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_court_bounce.sv
// tb/tb_court_bounce.sv - self-checking bench for court_bounce
module tb_court_bounce;

  localparam int COOL = 4;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [10:0] ball_pos_x, ball_pos_y;
  logic [9:0]  ball_v_x, ball_v_y, new_ball_v_x, new_ball_v_y;
  logic [3:0]  hit_mask;
  logic [1:0]  net_case;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int vx;
    int vy;
    int hm;
    int nc;
  } res_t;

  res_t q[$];
  int   mcx = 0;
  int   mcy = 0;

  court_bounce dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ball_pos_x   (ball_pos_x),
    .ball_pos_y   (ball_pos_y),
    .ball_v_x     (ball_v_x),
    .ball_v_y     (ball_v_y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .new_ball_v_x (new_ball_v_x),
    .new_ball_v_y (new_ball_v_y),
    .hit_mask     (hit_mask),
    .net_case     (net_case)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int negsat(int v);
    return (v == -512) ? 511 : -v;
  endfunction

  function automatic int rpos(int v);
    if (v < -10) return negsat(v);
    if (v >= -10 && v <= 10) return 20;
    return v;
  endfunction

  function automatic int rneg(int v);
    if (v > 10) return negsat(v);
    if (v >= -10 && v <= 10) return -20;
    return v;
  endfunction

  // Reference behaviour from the court rules, advancing the model cooldowns.
  function automatic res_t model(int px, int py, int vx, int vy);
    res_t r;
    bit left, right, wall, nz, fl, fr, ceil, top;
    left  = px <= 38;
    right = !left && px >= 592;
    wall  = left || right;
    nz    = py >= 270;
    fl    = !wall && nz && px >= 285 && px <= 295;
    fr    = !wall && nz && !fl && px >= 325 && px <= 335;
    ceil  = py <= 38;
    top   = !ceil && !wall && !fl && !fr && nz && px > 295 && px < 325;
    r.vx = vx; r.vy = vy; r.hm = 0; r.nc = 0;
    if (mcx != 0) mcx--;
    else if (wall || fl || fr) begin
      r.vx = (left || fr) ? rpos(vx) : rneg(vx);
      if (left)  r.hm += 1;
      if (right) r.hm += 2;
      if (fl || fr) r.hm += 8;
      r.nc = fl ? 1 : (fr ? 2 : 0);
      mcx = COOL;
    end
    if (mcy != 0) mcy--;
    else if (ceil || top) begin
      r.vy = ceil ? rpos(vy) : rneg(vy);
      r.hm += ceil ? 4 : 8;
      if (top) r.nc = 3;
      mcy = COOL;
    end
    return r;
  endfunction

  // Cycle-by-cycle compare against the scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    bit exp_rdy;
    exp_rdy = (q.size() == 0) || out_ready;
    check("out_valid", int'(out_valid), int'(q.size() != 0));
    check("in_ready", int'(in_ready), int'(exp_rdy));
    if (q.size() != 0 && out_valid) begin
      check("mon_vx", $signed(new_ball_v_x), q[0].vx);
      check("mon_vy", $signed(new_ball_v_y), q[0].vy);
      check("mon_hit_mask", int'(hit_mask), q[0].hm);
      check("mon_net_case", int'(net_case), q[0].nc);
    end
    if (q.size() != 0 && out_ready) void'(q.pop_front());
    if (rst) begin
      q.delete();
      mcx = 0;
      mcy = 0;
    end else if (in_valid && exp_rdy) begin
      q.push_back(model($signed(ball_pos_x), $signed(ball_pos_y),
                        $signed(ball_v_x), $signed(ball_v_y)));
    end
  end

  task automatic drive(input int px, input int py, input int vx, input int vy);
    ball_pos_x = 11'(px);
    ball_pos_y = 11'(py);
    ball_v_x   = 10'(vx);
    ball_v_y   = 10'(vy);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One sample with out_ready high; result checked one cycle after accept.
  task automatic send_chk(input string name, input int px, input int py, input int vx,
                          input int vy, input int evx, input int evy, input int ehm,
                          input int enc);
    @(posedge clk); #1;
    drive(px, py, vx, vy);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_vx"}, $signed(new_ball_v_x), evx);
    check({name, "_vy"}, $signed(new_ball_v_y), evy);
    check({name, "_hm"}, int'(hit_mask), ehm);
    check({name, "_nc"}, int'(net_case), enc);
  endtask

  function automatic int pick_x();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 1000)) - 200;
      1:       return int'($urandom_range(20, 50));
      2:       return int'($urandom_range(580, 610));
      default: return int'($urandom_range(280, 340));
    endcase
  endfunction

  function automatic int pick_y();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 600)) - 100;
      1:       return int'($urandom_range(20, 50));
      default: return int'($urandom_range(260, 400));
    endcase
  endfunction

  function automatic int pick_v();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 24)) - 12;
      1:       return ($urandom_range(0, 1) == 0) ? -512 : 511;
      default: return int'($urandom_range(0, 1023)) - 512;
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid", int'(out_valid), 0);
    check("reset_vx", int'(new_ball_v_x), 0);
    check("reset_hm", int'(hit_mask), 0);
    check("reset_nc", int'(net_case), 0);
    #1 rst = 1'b0;

    do_reset(); send_chk("left_wall", 30, 200, -50, 7, 50, 7, 1, 0);
    do_reset(); send_chk("slow_corner", 600, 20, 3, -4, -20, 20, 6, 0);
    do_reset(); send_chk("net_left", 290, 300, 15, 0, -15, 0, 8, 1);
    do_reset(); send_chk("net_right", 330, 300, -5, 0, 20, 0, 8, 2);
    do_reset(); send_chk("net_top", 310, 280, 0, 30, 0, -30, 8, 3);
    do_reset(); send_chk("saturate", 30, 200, -512, 0, 511, 0, 1, 0);

    do_reset();
    send_chk("cool1", 30, 200, -50, 0, 50, 0, 1, 0);
    for (int i = 2; i <= 5; i++)
      send_chk($sformatf("cool%0d", i), 30, 200, -50, 0, -50, 0, 0, 0);
    send_chk("cool6", 30, 200, -50, 0, 50, 0, 1, 0);

    // Backpressure: A stalls for three cycles while B waits at the input.
    do_reset();
    @(posedge clk); #1;
    drive(30, 200, -50, 7); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    drive(200, 20, 5, -30);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_vx", $signed(new_ball_v_x), 50);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_b_valid", int'(out_valid), 1);
    check("bp_b_vx", $signed(new_ball_v_x), 5);
    check("bp_b_vy", $signed(new_ball_v_y), 30);
    check("bp_b_hm", int'(hit_mask), 4);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drained", int'(out_valid), 0);

    // Reset with a pending result and a simultaneous accept.
    do_reset();
    @(posedge clk); #1;
    drive(30, 200, -50, 7); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_vx", int'(new_ball_v_x), 0);
    check("rst_vy", int'(new_ball_v_y), 0);
    check("rst_hm", int'(hit_mask), 0);
    check("rst_nc", int'(net_case), 0);

    // Randomised traffic, checked by the scoreboard process.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      drive(pick_x(), pick_y(), pick_v(), pick_v());
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("final_empty", int'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
